// File: rtl/dec_issue.sv
// Decode-to-execute issue stage: resolves operands from RF, forwarding ports or writeback,
// interlocks on pending long-latency destinations, and registers the result into EXE.
module dec_issue #(
    parameter int XLEN  = 32,
    parameter int NB_FF = 2,
    parameter int OPW   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic                    rs1_v_i,
    input  logic [4:0]              rs1_adr_i,
    input  logic                    rs2_v_i,
    input  logic [4:0]              rs2_adr_i,
    input  logic                    imm_v_i,
    input  logic [XLEN-1:0]         imm_i,
    input  logic                    auipc_i,
    input  logic                    unsign_i,
    input  logic                    neg_rs2_i,
    input  logic                    rd_v_i,
    input  logic [4:0]              rd_adr_i,
    input  logic                    long_i,
    input  logic [OPW-1:0]          op_i,
    output logic [4:0]              rf_rs1_adr_o,
    output logic [4:0]              rf_rs2_adr_o,
    input  logic [XLEN-1:0]         rf_rs1_data_i,
    input  logic [XLEN-1:0]         rf_rs2_data_i,
    input  logic [NB_FF-1:0]        ff_v_i,
    input  logic [5*NB_FF-1:0]      ff_rd_adr_i,
    input  logic [NB_FF-1:0]        ff_data_v_i,
    input  logic [XLEN*NB_FF-1:0]   ff_data_i,
    input  logic                    wb_v_i,
    input  logic [4:0]              wb_adr_i,
    input  logic [XLEN-1:0]         wb_data_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         pc_q_o,
    output logic                    rd_v_q_o,
    output logic [4:0]              rd_adr_q_o,
    output logic                    long_q_o,
    output logic [OPW-1:0]          op_q_o,
    output logic [XLEN:0]           rs1_q_o,
    output logic [XLEN:0]           rs2_q_o,
    output logic [XLEN-1:0]         imm_q_o,
    output logic                    stall_o
);

    logic [31:0]   r_sb;
    logic [31:0]   w_sb_nxt;
    logic [XLEN:0] w_res1;
    logic [XLEN:0] w_res2;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN:0] w_op1_ext;
    logic [XLEN:0] w_op2_ext;
    logic [XLEN:0] w_op2_fin;
    logic          w_hazard;
    logic          w_issue;
    logic          w_handoff_long;

    // Returns {hazard, value}; port 0 is the youngest producer so the first match wins.
    function automatic logic [XLEN:0] f_resolve(
        input logic                  v,
        input logic [4:0]            adr,
        input logic [XLEN-1:0]       rf,
        input logic [NB_FF-1:0]      ffv,
        input logic [5*NB_FF-1:0]    ffa,
        input logic [NB_FF-1:0]      ffdv,
        input logic [XLEN*NB_FF-1:0] ffd,
        input logic                  wbv,
        input logic [4:0]            wba,
        input logic [XLEN-1:0]       wbd,
        input logic [31:0]           sb
    );
        logic            found;
        logic            haz;
        logic [XLEN-1:0] val;
        found = 1'b0;
        haz   = 1'b0;
        val   = '0;
        if (v && (adr != 5'd0)) begin
            for (int unsigned k = 0; k < NB_FF; k++) begin
                if (!found && ffv[k] && (ffa[k*5 +: 5] == adr)) begin
                    found = 1'b1;
                    if (ffdv[k]) val = ffd[k*XLEN +: XLEN];
                    else         haz = 1'b1;
                end
            end
            if (!found) begin
                if (wbv && (wba == adr)) val = wbd;
                else if (sb[adr])        haz = 1'b1;
                else                     val = rf;
            end
        end
        return {haz, val};
    endfunction

    assign rf_rs1_adr_o = rs1_adr_i;
    assign rf_rs2_adr_o = rs2_adr_i;

    assign w_res1 = f_resolve(rs1_v_i, rs1_adr_i, rf_rs1_data_i, ff_v_i, ff_rd_adr_i,
                              ff_data_v_i, ff_data_i, wb_v_i, wb_adr_i, wb_data_i, r_sb);
    assign w_res2 = f_resolve(rs2_v_i, rs2_adr_i, rf_rs2_data_i, ff_v_i, ff_rd_adr_i,
                              ff_data_v_i, ff_data_i, wb_v_i, wb_adr_i, wb_data_i, r_sb);

    assign w_op1     = w_res1[XLEN-1:0] | (auipc_i ? pc_i : '0);
    assign w_op2     = w_res2[XLEN-1:0] | (imm_v_i ? imm_i : '0);
    assign w_op1_ext = {~unsign_i & w_op1[XLEN-1], w_op1};
    assign w_op2_ext = {~unsign_i & w_op2[XLEN-1], w_op2};
    assign w_op2_fin = neg_rs2_i ? (~w_op2_ext + {{XLEN{1'b0}}, 1'b1}) : w_op2_ext;

    assign w_hazard   = w_res1[XLEN] | w_res2[XLEN];
    assign stall_o    = in_valid_i & w_hazard & ~flush_i;
    assign w_issue    = in_valid_i & ~stall_o & (~out_valid_o | out_ready_i) & ~flush_i;
    assign in_ready_o = w_issue | flush_i;

    assign w_handoff_long = out_valid_o & out_ready_i & ~flush_i & rd_v_q_o & long_q_o;

    // Set is applied after clear so a same-cycle set/clear of one register leaves it pending.
    always_comb begin
        w_sb_nxt = r_sb;
        if (wb_v_i)         w_sb_nxt[wb_adr_i]   = 1'b0;
        if (w_handoff_long) w_sb_nxt[rd_adr_q_o] = 1'b1;
        w_sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb        <= '0;
            out_valid_o <= 1'b0;
            pc_q_o      <= '0;
            rd_v_q_o    <= 1'b0;
            rd_adr_q_o  <= '0;
            long_q_o    <= 1'b0;
            op_q_o      <= '0;
            rs1_q_o     <= '0;
            rs2_q_o     <= '0;
            imm_q_o     <= '0;
        end else begin
            r_sb <= w_sb_nxt;
            if (flush_i) begin
                out_valid_o <= 1'b0;
            end else if (w_issue) begin
                out_valid_o <= 1'b1;
                pc_q_o      <= pc_i;
                rd_v_q_o    <= rd_v_i;
                rd_adr_q_o  <= rd_adr_i;
                long_q_o    <= long_i;
                op_q_o      <= op_i;
                rs1_q_o     <= w_op1_ext;
                rs2_q_o     <= w_op2_fin;
                imm_q_o     <= imm_i;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dec_issue.sv
// Scoreboard bench for dec_issue: expected operands are queued at acceptance and compared
// when EXE takes the instruction.
module tb_dec_issue;
    localparam int XLEN  = 32;
    localparam int NB_FF = 2;
    localparam int OPW   = 16;

    logic clk, reset;
    logic in_valid_i, in_ready_o;
    logic [XLEN-1:0] pc_i, imm_i;
    logic rs1_v_i, rs2_v_i, imm_v_i, auipc_i, unsign_i, neg_rs2_i, rd_v_i, long_i;
    logic [4:0] rs1_adr_i, rs2_adr_i, rd_adr_i;
    logic [OPW-1:0] op_i;
    logic [4:0] rf_rs1_adr_o, rf_rs2_adr_o;
    logic [XLEN-1:0] rf_rs1_data_i, rf_rs2_data_i;
    logic [NB_FF-1:0] ff_v_i, ff_data_v_i;
    logic [5*NB_FF-1:0] ff_rd_adr_i;
    logic [XLEN*NB_FF-1:0] ff_data_i;
    logic wb_v_i;
    logic [4:0] wb_adr_i;
    logic [XLEN-1:0] wb_data_i;
    logic flush_i, out_valid_o, out_ready_i;
    logic [XLEN-1:0] pc_q_o, imm_q_o;
    logic rd_v_q_o, long_q_o, stall_o;
    logic [4:0] rd_adr_q_o;
    logic [OPW-1:0] op_q_o;
    logic [XLEN:0] rs1_q_o, rs2_q_o;

    logic [XLEN-1:0] rf_mem [32];
    assign rf_rs1_data_i = rf_mem[rf_rs1_adr_o];
    assign rf_rs2_data_i = rf_mem[rf_rs2_adr_o];

    dec_issue #(.XLEN(XLEN), .NB_FF(NB_FF), .OPW(OPW)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i),
        .rs1_v_i(rs1_v_i), .rs1_adr_i(rs1_adr_i),
        .rs2_v_i(rs2_v_i), .rs2_adr_i(rs2_adr_i),
        .imm_v_i(imm_v_i), .imm_i(imm_i),
        .auipc_i(auipc_i), .unsign_i(unsign_i), .neg_rs2_i(neg_rs2_i),
        .rd_v_i(rd_v_i), .rd_adr_i(rd_adr_i), .long_i(long_i), .op_i(op_i),
        .rf_rs1_adr_o(rf_rs1_adr_o), .rf_rs2_adr_o(rf_rs2_adr_o),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .ff_v_i(ff_v_i), .ff_rd_adr_i(ff_rd_adr_i),
        .ff_data_v_i(ff_data_v_i), .ff_data_i(ff_data_i),
        .wb_v_i(wb_v_i), .wb_adr_i(wb_adr_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_q_o(pc_q_o), .rd_v_q_o(rd_v_q_o), .rd_adr_q_o(rd_adr_q_o),
        .long_q_o(long_q_o), .op_q_o(op_q_o),
        .rs1_q_o(rs1_q_o), .rs2_q_o(rs2_q_o), .imm_q_o(imm_q_o),
        .stall_o(stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN:0]   rs1;
        logic [XLEN:0]   rs2;
        logic [54:0]     meta;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_fail = 0;
    logic [XLEN:0] exp_rs1, exp_rs2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        in_valid_i = 1'b0; pc_i = '0; imm_i = '0; op_i = '0;
        rs1_v_i = 1'b0; rs1_adr_i = '0; rs2_v_i = 1'b0; rs2_adr_i = '0;
        imm_v_i = 1'b0; auipc_i = 1'b0; unsign_i = 1'b0; neg_rs2_i = 1'b0;
        rd_v_i = 1'b0; rd_adr_i = '0; long_i = 1'b0;
        ff_v_i = '0; ff_rd_adr_i = '0; ff_data_v_i = '0; ff_data_i = '0;
        wb_v_i = 1'b0; wb_adr_i = '0; wb_data_i = '0; flush_i = 1'b0;
    endtask

    task automatic alu(input logic [XLEN-1:0] pc, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] rd);
        idle_in();
        in_valid_i = 1'b1; pc_i = pc; op_i = pc[15:0];
        rs1_v_i = 1'b1; rs1_adr_i = a1;
        rs2_v_i = 1'b1; rs2_adr_i = a2;
        rd_v_i = 1'b1; rd_adr_i = rd;
    endtask

    // Samples just before the rising edge, then advances to the next falling edge.
    task automatic cyc(input string tag, input logic exp_stall, input logic exp_rdy);
        exp_t e;
        #4;
        chk({tag, "_stall"}, 64'(stall_o), 64'(exp_stall));
        chk({tag, "_in_ready"}, 64'(in_ready_o), 64'(exp_rdy));
        if (out_valid_o && (out_ready_i || flush_i)) begin
            if (q.size() == 0) begin
                chk({tag, "_spurious_out"}, 64'(1), 64'(0));
            end else begin
                e = q.pop_front();
                if (!flush_i) begin
                    chk({tag, "_pc_q"}, 64'(pc_q_o), 64'(e.pc));
                    chk({tag, "_rs1_q"}, 64'(rs1_q_o), 64'(e.rs1));
                    chk({tag, "_rs2_q"}, 64'(rs2_q_o), 64'(e.rs2));
                    chk({tag, "_fields_q"},
                        64'({rd_v_q_o, rd_adr_q_o, long_q_o, op_q_o, imm_q_o}), 64'(e.meta));
                end
            end
        end
        if (in_valid_i && in_ready_o && !flush_i) begin
            e.pc   = pc_i;
            e.rs1  = exp_rs1;
            e.rs2  = exp_rs2;
            e.meta = {rd_v_i, rd_adr_i, long_i, op_i, imm_i};
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 | 32'(i);
        rf_mem[1] = 32'd1;  rf_mem[2] = 32'd5;  rf_mem[3] = 32'd7;
        rf_mem[5] = 32'd9;  rf_mem[6] = 32'd11; rf_mem[8] = 32'h88;
        rf_mem[12] = 32'h8000_0000;
        idle_in();
        out_ready_i = 1'b1;
        reset = 1'b1;
        exp_rs1 = '0; exp_rs2 = '0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_pc_q", 64'(pc_q_o), 64'(0));
        chk("rst_rs1_q", 64'(rs1_q_o), 64'(0));
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_in_ready", 64'(in_ready_o), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // back-to-back independent
        alu(32'h100, 5'd2, 5'd3, 5'd1); exp_rs1 = 33'd5; exp_rs2 = 33'd7;
        cyc("b2b_a", 1'b0, 1'b1);
        chk("b2b_ov1", 64'(out_valid_o), 64'(1));
        alu(32'h104, 5'd5, 5'd6, 5'd4); exp_rs1 = 33'd9; exp_rs2 = 33'd11;
        cyc("b2b_b", 1'b0, 1'b1);
        chk("b2b_ov2", 64'(out_valid_o), 64'(1));
        idle_in(); cyc("b2b_idle", 1'b0, 1'b0);
        chk("b2b_ov3", 64'(out_valid_o), 64'(0));

        // forwarding priority, then wait on port 0 data
        alu(32'h200, 5'd3, 5'd0, 5'd5); rs2_v_i = 1'b0;
        ff_v_i = 2'b11; ff_rd_adr_i = {5'd3, 5'd3}; ff_data_v_i = 2'b11;
        ff_data_i = {32'h22, 32'h11};
        exp_rs1 = 33'h11; exp_rs2 = 33'd0;
        cyc("ff_pri", 1'b0, 1'b1);
        alu(32'h204, 5'd3, 5'd0, 5'd5); rs2_v_i = 1'b0;
        ff_v_i = 2'b11; ff_rd_adr_i = {5'd3, 5'd3}; ff_data_v_i = 2'b10;
        ff_data_i = {32'h22, 32'h11};
        cyc("ff_wait1", 1'b1, 1'b0);
        cyc("ff_wait2", 1'b1, 1'b0);
        ff_data_v_i = 2'b11;
        cyc("ff_go", 1'b0, 1'b1);
        idle_in(); cyc("ff_drain", 1'b0, 1'b0);

        // long-latency load-use interlock
        alu(32'h300, 5'd2, 5'd0, 5'd8); rs2_v_i = 1'b0; long_i = 1'b1;
        imm_v_i = 1'b1; imm_i = 32'd4;
        exp_rs1 = 33'd5; exp_rs2 = 33'd4;
        cyc("ld_issue", 1'b0, 1'b1);
        idle_in(); cyc("ld_handoff", 1'b0, 1'b0);
        alu(32'h304, 5'd8, 5'd0, 5'd9); rs2_v_i = 1'b0;
        cyc("lu_stall1", 1'b1, 1'b0);
        cyc("lu_stall2", 1'b1, 1'b0);
        wb_v_i = 1'b1; wb_adr_i = 5'd8; wb_data_i = 32'hDEAD;
        exp_rs1 = 33'hDEAD; exp_rs2 = 33'd0;
        cyc("lu_wb", 1'b0, 1'b1);
        alu(32'h308, 5'd8, 5'd0, 5'd9); rs2_v_i = 1'b0;
        exp_rs1 = 33'h88;
        cyc("sb_clr8", 1'b0, 1'b1);
        idle_in(); cyc("lu_drain", 1'b0, 1'b0);

        // backpressure
        out_ready_i = 1'b0;
        alu(32'h400, 5'd2, 5'd3, 5'd1); exp_rs1 = 33'd5; exp_rs2 = 33'd7;
        cyc("bp_a", 1'b0, 1'b1);
        alu(32'h404, 5'd5, 5'd6, 5'd4);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ov", 64'(out_valid_o), 64'(1));
            chk("bp_pc_hold", 64'(pc_q_o), 64'(32'h400));
            cyc("bp_hold", 1'b0, 1'b0);
        end
        out_ready_i = 1'b1;
        exp_rs1 = 33'd9; exp_rs2 = 33'd11;
        cyc("bp_release", 1'b0, 1'b1);
        chk("bp_b_pc", 64'(pc_q_o), 64'(32'h404));
        idle_in(); cyc("bp_drain", 1'b0, 1'b0);

        // flush with a long load in the output register
        alu(32'h500, 5'd2, 5'd0, 5'd10); rs2_v_i = 1'b0; long_i = 1'b1;
        exp_rs1 = 33'd5; exp_rs2 = 33'd0;
        cyc("fl_l10", 1'b0, 1'b1);
        idle_in(); cyc("fl_h10", 1'b0, 1'b0);
        alu(32'h504, 5'd2, 5'd0, 5'd8); rs2_v_i = 1'b0; long_i = 1'b1;
        cyc("fl_l8", 1'b0, 1'b1);
        alu(32'h508, 5'd8, 5'd0, 5'd9); rs2_v_i = 1'b0; flush_i = 1'b1;
        cyc("fl_flush", 1'b0, 1'b1);
        chk("fl_ov", 64'(out_valid_o), 64'(0));
        alu(32'h50C, 5'd8, 5'd0, 5'd9); rs2_v_i = 1'b0;
        exp_rs1 = 33'h88; exp_rs2 = 33'd0;
        cyc("fl_sb8", 1'b0, 1'b1);
        alu(32'h510, 5'd10, 5'd0, 5'd11); rs2_v_i = 1'b0;
        cyc("fl_sb10", 1'b1, 1'b0);
        wb_v_i = 1'b1; wb_adr_i = 5'd10; wb_data_i = 32'h1010;
        exp_rs1 = 33'h1010;
        cyc("fl_wb10", 1'b0, 1'b1);

        // operand arithmetic and x0
        alu(32'h600, 5'd0, 5'd1, 5'd0); rs1_v_i = 1'b0; rd_v_i = 1'b0; neg_rs2_i = 1'b1;
        exp_rs1 = 33'd0; exp_rs2 = 33'h1_FFFF_FFFF;
        cyc("ar_neg", 1'b0, 1'b1);
        alu(32'h604, 5'd12, 5'd0, 5'd13); rs2_v_i = 1'b0; unsign_i = 1'b1;
        exp_rs1 = 33'h0_8000_0000; exp_rs2 = 33'd0;
        cyc("ar_unsign", 1'b0, 1'b1);
        alu(32'h608, 5'd12, 5'd0, 5'd13); rs2_v_i = 1'b0;
        exp_rs1 = 33'h1_8000_0000;
        cyc("ar_sign", 1'b0, 1'b1);
        idle_in(); in_valid_i = 1'b1; pc_i = 32'h1000; op_i = 16'h1000;
        auipc_i = 1'b1; imm_v_i = 1'b1; imm_i = 32'h10; rd_v_i = 1'b1; rd_adr_i = 5'd7;
        exp_rs1 = 33'h1000; exp_rs2 = 33'h10;
        cyc("ar_auipc", 1'b0, 1'b1);
        alu(32'h610, 5'd2, 5'd0, 5'd3); rs2_v_i = 1'b0; imm_v_i = 1'b1; imm_i = 32'hFFFF_FFFC;
        exp_rs1 = 33'd5; exp_rs2 = 33'h1_FFFF_FFFC;
        cyc("ar_imm", 1'b0, 1'b1);
        alu(32'h614, 5'd0, 5'd0, 5'd1);
        ff_v_i = 2'b01; ff_rd_adr_i = '0; ff_data_v_i = 2'b00; ff_data_i = {32'h22, 32'h11};
        exp_rs1 = 33'd0; exp_rs2 = 33'd0;
        cyc("ar_x0", 1'b0, 1'b1);

        idle_in();
        for (int i = 0; i < 10 && q.size() != 0; i++) cyc("drain", 1'b0, 1'b0);
        chk("drain_empty", 64'(q.size()), 64'(0));

        // reset mid-operation
        alu(32'h700, 5'd2, 5'd0, 5'd10); rs2_v_i = 1'b0; long_i = 1'b1;
        exp_rs1 = 33'd5; exp_rs2 = 33'd0;
        cyc("mr_ld", 1'b0, 1'b1);
        idle_in(); cyc("mr_handoff", 1'b0, 1'b0);
        alu(32'h704, 5'd2, 5'd3, 5'd4); exp_rs1 = 33'd5; exp_rs2 = 33'd7;
        cyc("mr_i2", 1'b0, 1'b1);
        idle_in(); out_ready_i = 1'b0; reset = 1'b1;
        #1;
        chk("mr_ov", 64'(out_valid_o), 64'(0));
        q.delete();
        @(negedge clk);
        reset = 1'b0; out_ready_i = 1'b1;
        alu(32'h708, 5'd10, 5'd0, 5'd11); rs2_v_i = 1'b0;
        exp_rs1 = 33'h1_A000_000A; exp_rs2 = 33'd0;
        cyc("mr_sb", 1'b0, 1'b1);
        idle_in(); cyc("mr_end", 1'b0, 1'b0);
        chk("mr_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
